decode_buffer_stage: RTL and testbench

DECODE_BUFFER_STAGE -- requirements
Module: decode_buffer_stage

---
 rtl/decode_buffer_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_decode_buffer_stage.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_buffer_stage.sv
// decode_buffer_stage: instruction queue between fetch and decode, followed by
// an RV32I/RV64I base-set decoder whose results land in a set of output registers.
// Optional feature: define DECODE_BUFFER_BYPASS_EN to let an instruction that
// arrives at an empty, unstalled queue skip storage and be decoded the same edge.
// Handshake: fetch transfers an instruction on a rising edge where
// valid_i & ready_o & ~squash_i; ready_o depends only on occupancy.
module decode_buffer_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     squash_i,
    input  logic                     stall_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          next_pc_i,
    input  logic [31:0]              inst_i,
    output logic [4:0]               rs1_idx_ao,
    output logic [4:0]               rs2_idx_ao,
    input  logic [XLEN-1:0]          rs1_data_i,
    input  logic [XLEN-1:0]          rs2_data_i,
    output logic                     valid_o,
    output logic [4:0]               rs1_idx_o,
    output logic [4:0]               rs2_idx_o,
    output logic [4:0]               rd_idx_o,
    output logic [XLEN-1:0]          rs1_data_o,
    output logic [XLEN-1:0]          rs2_data_o,
    output logic                     rd_wr_en_o,
    output logic                     mem_rd_o,
    output logic                     mem_wr_o,
    output logic                     illegal_o,
    output logic [XLEN-1:0]          imm_o,
    output logic [XLEN-1:0]          pc_o,
    output logic [XLEN-1:0]          next_pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic           IS32     = (XLEN == 32);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_W = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP_W     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Queue storage (not reset: contents are only read when count says valid)
    logic [XLEN-1:0] pc_mem      [DEPTH];
    logic [XLEN-1:0] next_pc_mem [DEPTH];
    logic [31:0]     inst_mem    [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic empty;
    logic bypass;
    logic enq;
    logic deq;

    assign empty   = (count == '0);
    assign ready_o = (count < FULL_CNT);
    assign count_o = count;

`ifdef DECODE_BUFFER_BYPASS_EN
    assign bypass = valid_i & empty & ~stall_i & ~squash_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction never occupies a slot
    assign enq = valid_i & ready_o & ~squash_i & ~bypass;
    assign deq = ~empty & ~stall_i & ~squash_i;

    // Instruction being decoded this cycle: head entry, or the incoming one when bypassing
    logic [31:0]     src_inst;
    logic [XLEN-1:0] src_pc;
    logic [XLEN-1:0] src_next_pc;

    assign src_inst    = bypass ? inst_i    : inst_mem[rd_ptr];
    assign src_pc      = bypass ? pc_i      : pc_mem[rd_ptr];
    assign src_next_pc = bypass ? next_pc_i : next_pc_mem[rd_ptr];

    assign rs1_idx_ao = src_inst[19:15];
    assign rs2_idx_ao = src_inst[24:20];

    // Decode fields and immediates
    logic        op_load, op_fence, op_imm, op_auipc, op_imm_w, op_store;
    logic        op_reg, op_lui, op_reg_w, op_branch, op_jalr, op_jal, op_system;
    logic        known;
    logic        dec_illegal;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_rd_wr_en;
    logic        dec_mem_rd;
    logic        dec_mem_wr;
    logic [XLEN-1:0] dec_imm;

    logic [11:0] imm_i12;
    logic [11:0] imm_s12;
    logic [12:0] imm_b13;
    logic [31:0] imm_u32;
    logic [20:0] imm_j21;

    assign imm_i12 = src_inst[31:20];
    assign imm_s12 = {src_inst[31:25], src_inst[11:7]};
    assign imm_b13 = {src_inst[31], src_inst[7], src_inst[30:25], src_inst[11:8], 1'b0};
    assign imm_u32 = {src_inst[31:12], 12'b0};
    assign imm_j21 = {src_inst[31], src_inst[19:12], src_inst[20], src_inst[30:21], 1'b0};

    // Classify the opcode and derive every decoded output field
    always_comb begin
        op_load   = (src_inst[6:0] == OPC_LOAD);
        op_fence  = (src_inst[6:0] == OPC_FENCE);
        op_imm    = (src_inst[6:0] == OPC_OP_IMM);
        op_auipc  = (src_inst[6:0] == OPC_AUIPC);
        op_imm_w  = (src_inst[6:0] == OPC_OP_IMM_W);
        op_store  = (src_inst[6:0] == OPC_STORE);
        op_reg    = (src_inst[6:0] == OPC_OP);
        op_lui    = (src_inst[6:0] == OPC_LUI);
        op_reg_w  = (src_inst[6:0] == OPC_OP_W);
        op_branch = (src_inst[6:0] == OPC_BRANCH);
        op_jalr   = (src_inst[6:0] == OPC_JALR);
        op_jal    = (src_inst[6:0] == OPC_JAL);
        op_system = (src_inst[6:0] == OPC_SYSTEM);

        known = op_load | op_fence | op_imm | op_auipc | op_imm_w | op_store | op_reg |
                op_lui | op_reg_w | op_branch | op_jalr | op_jal | op_system;

        // 32-bit builds reject the W-ops and doubleword loads/stores
        dec_illegal = ~known
                    | (src_inst[1:0] != 2'b11)
                    | (IS32 & (op_imm_w | op_reg_w))
                    | (IS32 & (op_load | op_store) & (src_inst[14:12] == 3'b011));

        dec_rs1 = (op_lui | op_auipc | op_jal) ? 5'd0 : src_inst[19:15];
        dec_rs2 = (op_branch | op_store | op_reg | op_reg_w) ? src_inst[24:20] : 5'd0;
        dec_rd  = src_inst[11:7];

        dec_rd_wr_en = ~(op_branch | op_store | op_system | dec_illegal) & (dec_rd != 5'd0);
        dec_mem_rd   = op_load & ~dec_illegal;
        dec_mem_wr   = op_store & ~dec_illegal;

        dec_imm = '0;
        if (!dec_illegal) begin
            if (op_load | op_fence | op_imm | op_imm_w | op_jalr | op_system)
                dec_imm = XLEN'($signed(imm_i12));
            else if (op_store)
                dec_imm = XLEN'($signed(imm_s12));
            else if (op_branch)
                dec_imm = XLEN'($signed(imm_b13));
            else if (op_lui | op_auipc)
                dec_imm = XLEN'($signed(imm_u32));
            else if (op_jal)
                dec_imm = XLEN'($signed(imm_j21));
        end
    end

    // Write the incoming instruction into the tail slot
    always_ff @(posedge clk_i) begin
        if (enq) begin
            pc_mem[wr_ptr]      <= pc_i;
            next_pc_mem[wr_ptr] <= next_pc_i;
            inst_mem[wr_ptr]    <= inst_i;
        end
    end

    // Pointer and occupancy bookkeeping; squash empties the queue
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (squash_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + AW'(1);
            if (deq)
                rd_ptr <= rd_ptr + AW'(1);
            case ({enq, deq})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Output registers: capture on dequeue/bypass, hold on stall, drop valid when starved
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            rs1_idx_o  <= '0;
            rs2_idx_o  <= '0;
            rd_idx_o   <= '0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            rd_wr_en_o <= 1'b0;
            mem_rd_o   <= 1'b0;
            mem_wr_o   <= 1'b0;
            illegal_o  <= 1'b0;
            imm_o      <= '0;
            pc_o       <= '0;
            next_pc_o  <= '0;
        end else if (squash_i) begin
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (deq | bypass) begin
                valid_o    <= 1'b1;
                rs1_idx_o  <= dec_rs1;
                rs2_idx_o  <= dec_rs2;
                rd_idx_o   <= dec_rd;
                rs1_data_o <= rs1_data_i;
                rs2_data_o <= rs2_data_i;
                rd_wr_en_o <= dec_rd_wr_en;
                mem_rd_o   <= dec_mem_rd;
                mem_wr_o   <= dec_mem_wr;
                illegal_o  <= dec_illegal;
                imm_o      <= dec_imm;
                pc_o       <= src_pc;
                next_pc_o  <= src_next_pc;
            end else begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_buffer_stage.sv
// Testbench for decode_buffer_stage: directed scenarios plus a randomized stream,
// checked against a queue-based reference model and an arithmetic RISC-V decoder.
module tb_decode_buffer_stage;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
`ifdef DECODE_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i = 1'b1;
    logic        squash_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [63:0] pc_i = '0;
    logic [63:0] next_pc_i = '0;
    logic [31:0] inst_i = '0;
    logic [63:0] rs1_data_i, rs2_data_i;

    logic        ready_o, valid_o, rd_wr_en_o, mem_rd_o, mem_wr_o, illegal_o;
    logic [4:0]  rs1_idx_ao, rs2_idx_ao, rs1_idx_o, rs2_idx_o, rd_idx_o;
    logic [63:0] rs1_data_o, rs2_data_o, imm_o, pc_o, next_pc_o;
    logic [2:0]  count_o;

    // Register file contents are a fixed function of the index
    function automatic logic [63:0] rf(input logic [4:0] i);
        return 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0000_0001_0001;
    endfunction

    assign rs1_data_i = rf(rs1_idx_ao);
    assign rs2_data_i = rf(rs2_idx_ao);

    decode_buffer_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .squash_i(squash_i), .stall_i(stall_i),
        .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i), .next_pc_i(next_pc_i),
        .inst_i(inst_i), .rs1_idx_ao(rs1_idx_ao), .rs2_idx_ao(rs2_idx_ao),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .valid_o(valid_o),
        .rs1_idx_o(rs1_idx_o), .rs2_idx_o(rs2_idx_o), .rd_idx_o(rd_idx_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .rd_wr_en_o(rd_wr_en_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .illegal_o(illegal_o),
        .imm_o(imm_o), .pc_o(pc_o), .next_pc_o(next_pc_o), .count_o(count_o)
    );

    // 32-bit instance, used only for width-dependent legality
    logic        valid_32 = 1'b0;
    logic        zero_32 = 1'b0;
    logic [31:0] inst_32 = '0;
    logic [31:0] pc_32 = 32'h100;
    logic [31:0] npc_32 = 32'h104;
    logic [31:0] rsd_32 = 32'h1234_5678;
    logic        ready_o32, valid_o32, rd_wr_en_o32, mem_rd_o32, mem_wr_o32, illegal_o32;
    logic [4:0]  rs1_ao32, rs2_ao32, rs1_o32, rs2_o32, rd_o32;
    logic [31:0] rs1d_o32, rs2d_o32, imm_o32, pc_o32, npc_o32;
    logic [1:0]  count_o32;

    decode_buffer_stage #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk_i(clk), .rst_i(rst_i), .squash_i(zero_32), .stall_i(zero_32),
        .valid_i(valid_32), .ready_o(ready_o32), .pc_i(pc_32), .next_pc_i(npc_32),
        .inst_i(inst_32), .rs1_idx_ao(rs1_ao32), .rs2_idx_ao(rs2_ao32),
        .rs1_data_i(rsd_32), .rs2_data_i(rsd_32), .valid_o(valid_o32),
        .rs1_idx_o(rs1_o32), .rs2_idx_o(rs2_o32), .rd_idx_o(rd_o32),
        .rs1_data_o(rs1d_o32), .rs2_data_o(rs2d_o32), .rd_wr_en_o(rd_wr_en_o32),
        .mem_rd_o(mem_rd_o32), .mem_wr_o(mem_wr_o32), .illegal_o(illegal_o32),
        .imm_o(imm_o32), .pc_o(pc_o32), .next_pc_o(npc_o32), .count_o(count_o32)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic [63:0] npc;
        logic [31:0] inst;
    } entry_t;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] rs1d, rs2d, imm, pc, npc;
        logic        we, mrd, mwr, ill;
    } dec_t;

    entry_t      q[$];
    dec_t        exp_dec;
    logic        exp_valid;
    logic        last_cap;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // RV64I base-set decode written from the instruction formats with integer arithmetic
    function automatic dec_t ref_dec(input entry_t e);
        dec_t        d;
        int unsigned w;
        int unsigned rd, r1, r2;
        longint      v;
        string       kind;
        w  = e.inst;
        rd = (w >> 7) & 31;
        r1 = (w >> 15) & 31;
        r2 = (w >> 20) & 31;
        case (w & 127)
            3:       kind = "LOAD";
            15:      kind = "FENCE";
            19:      kind = "OPIMM";
            23:      kind = "AUIPC";
            27:      kind = "OPIMMW";
            35:      kind = "STORE";
            51:      kind = "OP";
            55:      kind = "LUI";
            59:      kind = "OPW";
            99:      kind = "BRANCH";
            103:     kind = "JALR";
            111:     kind = "JAL";
            115:     kind = "SYSTEM";
            default: kind = "";
        endcase
        v = 0;
        if (kind == "LOAD" || kind == "FENCE" || kind == "OPIMM" || kind == "OPIMMW" ||
            kind == "JALR" || kind == "SYSTEM") begin
            v = longint'(w >> 20);
            if (v >= 2048) v -= 4096;
        end else if (kind == "STORE") begin
            v = longint'(((w >> 25) << 5) | rd);
            if (v >= 2048) v -= 4096;
        end else if (kind == "BRANCH") begin
            v = longint'((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                         (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1));
            if (v >= 4096) v -= 8192;
        end else if (kind == "LUI" || kind == "AUIPC") begin
            v = longint'(int'(w & 32'hFFFF_F000));
        end else if (kind == "JAL") begin
            v = longint'((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                         (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1));
            if (v >= 1048576) v -= 2097152;
        end
        d.ill  = (kind == "");
        d.rd   = 5'(rd);
        d.rs1  = (kind == "LUI" || kind == "AUIPC" || kind == "JAL") ? 5'd0 : 5'(r1);
        d.rs2  = (kind == "BRANCH" || kind == "STORE" || kind == "OP" || kind == "OPW") ? 5'(r2) : 5'd0;
        d.rs1d = rf(5'(r1));
        d.rs2d = rf(5'(r2));
        d.we   = !(kind == "BRANCH" || kind == "STORE" || kind == "SYSTEM" || d.ill || rd == 0);
        d.mrd  = (kind == "LOAD");
        d.mwr  = (kind == "STORE");
        d.imm  = 64'(v);
        d.pc   = e.pc;
        d.npc  = e.npc;
        return d;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid_o", valid_o, exp_valid);
        chk("count_o", count_o, q.size());
        chk("ready_o", ready_o, q.size() < DEPTH);
        chk("rs1_idx_o", rs1_idx_o, exp_dec.rs1);
        chk("rs2_idx_o", rs2_idx_o, exp_dec.rs2);
        chk("rd_idx_o", rd_idx_o, exp_dec.rd);
        chk("rs1_data_o", rs1_data_o, exp_dec.rs1d);
        chk("rs2_data_o", rs2_data_o, exp_dec.rs2d);
        chk("rd_wr_en_o", rd_wr_en_o, exp_dec.we);
        chk("mem_rd_o", mem_rd_o, exp_dec.mrd);
        chk("mem_wr_o", mem_wr_o, exp_dec.mwr);
        chk("illegal_o", illegal_o, exp_dec.ill);
        chk("imm_o", imm_o, exp_dec.imm);
        chk("pc_o", pc_o, exp_dec.pc);
        chk("next_pc_o", next_pc_o, exp_dec.npc);
    endtask

    // ---------------- driver tasks ----------------
    // One clock: drive at negedge, check combinational indices, update model at posedge, check outputs
    task automatic step(input logic v, input logic st, input logic sq,
                        input logic [31:0] ins, input logic [63:0] pc, output logic acc);
        entry_t off;
        entry_t e;
        int     size0;
        logic   byp;
        logic   cap;
        @(negedge clk);
        valid_i = v; stall_i = st; squash_i = sq; inst_i = ins;
        pc_i = pc; next_pc_i = pc + 64'd4;
        #1;
        if (q.size() != 0) begin
            chk("rs1_idx_ao", rs1_idx_ao, q[0].inst[19:15]);
            chk("rs2_idx_ao", rs2_idx_ao, q[0].inst[24:20]);
        end else if (BYP && v && !st && !sq) begin
            chk("rs1_idx_ao_byp", rs1_idx_ao, ins[19:15]);
            chk("rs2_idx_ao_byp", rs2_idx_ao, ins[24:20]);
        end
        off = '{pc, pc + 64'd4, ins};
        e   = off;
        @(posedge clk);
        size0 = q.size();
        byp = 1'b0; cap = 1'b0; acc = 1'b0;
        if (sq) begin
            q.delete();
            exp_valid = 1'b0;
        end else begin
            if (size0 != 0 && !st) begin
                e = q.pop_front();
                cap = 1'b1;
            end else if (BYP && size0 == 0 && !st && v) begin
                cap = 1'b1; byp = 1'b1; acc = 1'b1;
            end else if (!st) begin
                exp_valid = 1'b0;
            end
            if (v && size0 < DEPTH && !byp) begin
                q.push_back(off);
                acc = 1'b1;
            end
        end
        if (cap) begin
            exp_valid = 1'b1;
            exp_dec = ref_dec(e);
        end
        last_cap = cap;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1; valid_i = 1'b0; stall_i = 1'b0; squash_i = 1'b0; inst_i = '0;
        #1;
        q.delete();
        exp_valid = 1'b0;
        exp_dec = '0;
        check_outputs();
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, a);
    endtask

    task automatic wait_valid(input string tag);
        logic a;
        for (int k = 0; k < 4; k++) begin
            if (valid_o) break;
            step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, a);
        end
        chk(tag, valid_o, 1'b1);
    endtask

    task automatic run32(input logic [31:0] ins);
        @(negedge clk);
        valid_32 = 1'b1; inst_32 = ins;
        @(negedge clk);
        valid_32 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (valid_o32) break;
            @(negedge clk);
        end
        chk("x32_valid", valid_o32, 1'b1);
    endtask

    function automatic logic [31:0] mk_add(input int i);
        return {7'b0, 5'd3, 5'd2, 3'b000, 5'(i + 1), 7'b0110011};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [13];
        ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
        r = $urandom();
        if ($urandom_range(0, 7) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 12)]};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic        a;
        logic [31:0] rin [10];
        int          idx;
        int          cyc;
        exp_valid = 1'b0;
        exp_dec = '0;
        last_cap = 1'b0;

        // Reset state
        do_reset();
        chk("reset_ready", ready_o, 1'b1);

        // ADDI x5,x0,-1 at 0x1000
        step(1'b1, 1'b0, 1'b0, 32'hFFF0_0293, 64'h1000, a);
`ifdef DECODE_BUFFER_BYPASS_EN
        chk("addi_latency_e", valid_o, 1'b1);
`else
        chk("addi_latency_e", valid_o, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, a);
        chk("addi_latency_e1", valid_o, 1'b1);
`endif
        chk("addi_rd", rd_idx_o, 5'd5);
        chk("addi_we", rd_wr_en_o, 1'b1);
        chk("addi_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rs2", rs2_idx_o, 5'd0);
        chk("addi_pc", pc_o, 64'h1000);

        // Stall with DEPTH+1 offers: fills, then refuses
        for (int i = 0; i <= DEPTH; i++) begin
            step(1'b1, 1'b1, 1'b0, mk_add(i), 64'h2000 + 64'(i * 4), a);
            if (a) exp_q.push_back(64'h2000 + 64'(i * 4));
        end
        chk("stall_ready", ready_o, 1'b0);
        chk("stall_count", count_o, DEPTH);
        chk("stall_hold_pc", pc_o, 64'h1000);
        chk("stall_accepts", exp_q.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, a);
            chk("release_order", pc_o, exp_q.pop_front());
        end
        idle(1);

        // Squash with three queued, valid and stall high
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, mk_add(i + 8), 64'h3000 + 64'(i * 4), a);
        chk("squash_pre_count", count_o, 3);
        step(1'b1, 1'b1, 1'b1, 32'h0010_0093, 64'h3100, a);
        chk("squash_count", count_o, 0);
        chk("squash_valid", valid_o, 1'b0);
        idle(1);
        chk("squash_lost", valid_o, 1'b0);

        // ADDW and LD are legal at XLEN=64
        step(1'b1, 1'b0, 1'b0, 32'h0020_833B, 64'h4000, a);
        wait_valid("addw64_valid");
        chk("addw64_ill", illegal_o, 1'b0);
        chk("addw64_we", rd_wr_en_o, 1'b1);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 32'h0001_3083, 64'h4100, a);
        wait_valid("ld64_valid");
        chk("ld64_ill", illegal_o, 1'b0);
        chk("ld64_mrd", mem_rd_o, 1'b1);
        idle(1);

        // Reset in the middle of a filled queue
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, mk_add(i + 12), 64'h5000 + 64'(i * 4), a);
        do_reset();
        step(1'b1, 1'b0, 1'b0, mk_add(20), 64'h5100, a);
        wait_valid("post_reset_valid");
        chk("post_reset_pc", pc_o, 64'h5100);
        idle(2);

        // Random stream of ten instructions with random stall and valid gaps
        for (int i = 0; i < 10; i++) rin[i] = rand_inst();
        idx = 0; cyc = 0;
        got_q.delete(); exp_q.delete();
        while (idx < 10 && cyc < 200) begin
            logic v, st;
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 2) == 0);
            step(v, st, 1'b0, rin[idx], 64'h8000 + 64'(idx * 4), a);
            if (v && a) begin
                exp_q.push_back(64'h8000 + 64'(idx * 4));
                idx++;
            end
            if (last_cap) got_q.push_back(pc_o);
            cyc++;
        end
        while (q.size() != 0 && cyc < 200) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, a);
            if (last_cap) got_q.push_back(pc_o);
            cyc++;
        end
        chk("stream_offered", idx, 10);
        chk("stream_emitted", got_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_q.size() && i < exp_q.size()) chk("stream_order", got_q[i], exp_q[i]);
        end
        idle(1);

        // 32-bit instance legality
        run32(32'h0020_833B);
        chk("addw32_ill", illegal_o32, 1'b1);
        chk("addw32_we", rd_wr_en_o32, 1'b0);
        run32(32'h0001_3083);
        chk("ld32_ill", illegal_o32, 1'b1);
        chk("ld32_mrd", mem_rd_o32, 1'b0);
        run32(32'hFFF0_0293);
        chk("addi32_ill", illegal_o32, 1'b0);
        chk("addi32_imm", imm_o32, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
